// File: rtl/writeback_pkg.sv
// writeback_pkg
//   Shared types and constants for the writeback stage and its store
//   controller.
//   - wb_state_t : writeback FSM state encoding
//   - REG_CODE_W : width of an architectural register code
//   - DATA_W     : datapath width
//   - REG_RDX    : register code execute uses for special destinations
package writeback_pkg;

  localparam int REG_CODE_W = 4;
  localparam int DATA_W     = 64;

  localparam logic [REG_CODE_W-1:0] REG_RDX = 4'd2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REG_WB  = 2'd1,
    MEM_REQ = 2'd2,
    HALTED  = 2'd3
  } wb_state_t;

endpackage

// File: rtl/writeback_store_ctrl.sv
// writeback_store_ctrl
//   Owns the memory-destination store handshake. A start pulse latches the
//   store address and data and raises the request on the next cycle; the
//   request is held with stable address/data until ack is sampled high.
//   Ports:
//     clk, reset        core clock, asynchronous active-high reset
//     startPulse        store accepted this cycle (one cycle)
//     storeAddr/Data    address and data to latch on startPulse
//     ack               memory accepted the store (ignored while not busy)
//     busy              request outstanding (drives memReqOut)
//     done              ack sampled this cycle while busy (combinational)
//     memAddr/memData   latched store address and data
module writeback_store_ctrl
  import writeback_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              startPulse,
  input  logic [DATA_W-1:0] storeAddr,
  input  logic [DATA_W-1:0] storeData,
  input  logic              ack,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] memAddr,
  output logic [DATA_W-1:0] memData
);

  logic              busy_p1;
  logic [DATA_W-1:0] addr_p1;
  logic [DATA_W-1:0] data_p1;

  // Request stage: busy, address and data registered on the start edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_p1 <= 1'b0;
      addr_p1 <= '0;
      data_p1 <= '0;
    end else begin
      if (startPulse) begin
        busy_p1 <= 1'b1;
        addr_p1 <= storeAddr;
        data_p1 <= storeData;
      end else if (done) begin
        busy_p1 <= 1'b0;
      end
    end
  end

  // Ack only counts while a request is outstanding.
  assign done    = busy_p1 && ack;
  assign busy    = busy_p1;
  assign memAddr = addr_p1;
  assign memData = data_p1;

endmodule

// File: rtl/writeback.sv
// writeback
//   Final pipeline stage: commits execute results to the register file,
//   performs memory-destination stores through a req/ack handshake, counts
//   retired instructions and latches halt on a kill instruction.
//   Optional feature macro: WB_BYPASS_EN adds forwarding outputs that
//   mirror the primary register write (or the special write when the
//   primary one is suppressed by an equal destination code).
//   Ports:
//     clk, reset                      clock, asynchronous active-high reset
//     isExecuteSuccessfulIn, killIn   execute result valid / kill qualifier
//     currentRipIn                    RIP of incoming instruction
//     aluResultIn, aluResultSpecialIn primary and special results
//     destRegIn, destRegSpecialIn     destination register codes
//     destRegSpecialValidIn           special write requested
//     isMemoryAccessDestIn            destination is memory
//     memoryAddressDestIn             store address
//     memAckIn                        store accepted by memory
//     regWrite*Out                    primary register-file write port
//     regWriteSpecial*Out             special register-file write port
//     memReqOut/memAddrOut/memDataOut store request
//     wbStallOut                      stage cannot accept a new result
//     haltOut                         sticky halt
//     retiredRipOut/retiredCountOut   last retired RIP / retire counter
//     bypass*Out (WB_BYPASS_EN only)  forwarding of the register write
module writeback
  import writeback_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  isExecuteSuccessfulIn,
  input  logic                  killIn,
  input  logic [DATA_W-1:0]     currentRipIn,
  input  logic [DATA_W-1:0]     aluResultIn,
  input  logic [DATA_W-1:0]     aluResultSpecialIn,
  input  logic [REG_CODE_W-1:0] destRegIn,
  input  logic [REG_CODE_W-1:0] destRegSpecialIn,
  input  logic                  destRegSpecialValidIn,
  input  logic                  isMemoryAccessDestIn,
  input  logic [DATA_W-1:0]     memoryAddressDestIn,
  input  logic                  memAckIn,
  output logic                  regWriteEnOut,
  output logic [REG_CODE_W-1:0] regWriteAddrOut,
  output logic [DATA_W-1:0]     regWriteDataOut,
  output logic                  regWriteSpecialEnOut,
  output logic [REG_CODE_W-1:0] regWriteSpecialAddrOut,
  output logic [DATA_W-1:0]     regWriteSpecialDataOut,
  output logic                  memReqOut,
  output logic [DATA_W-1:0]     memAddrOut,
  output logic [DATA_W-1:0]     memDataOut,
  output logic                  wbStallOut,
  output logic                  haltOut,
  output logic [DATA_W-1:0]     retiredRipOut,
  output logic [DATA_W-1:0]     retiredCountOut
`ifdef WB_BYPASS_EN
  ,
  output logic                  bypassValidOut,
  output logic [REG_CODE_W-1:0] bypassRegOut,
  output logic [DATA_W-1:0]     bypassDataOut
`endif
);

  wb_state_t state, stateNext;

  logic [DATA_W-1:0]     rip_p1;
  logic [DATA_W-1:0]     result_p1;
  logic [DATA_W-1:0]     resultSpecial_p1;
  logic [REG_CODE_W-1:0] destReg_p1;
  logic [REG_CODE_W-1:0] destRegSpecial_p1;
  logic                  specialValid_p1;

  logic [DATA_W-1:0] retiredRip;
  logic [DATA_W-1:0] retiredCount;

  logic accept;
  logic startStore;
  logic storeBusy;
  logic storeDone;
  logic specialShadows;
  logic retireOld;
  logic retireKill;

  assign accept     = isExecuteSuccessfulIn && !wbStallOut;
  assign startStore = accept && !killIn && isMemoryAccessDestIn;

  // Store handshake sub-block; it latches the store address and data.
  writeback_store_ctrl u_storeCtrl (
    .clk       (clk),
    .reset     (reset),
    .startPulse(startStore),
    .storeAddr (memoryAddressDestIn),
    .storeData (aluResultIn),
    .ack       (memAckIn),
    .busy      (storeBusy),
    .done      (storeDone),
    .memAddr   (memAddrOut),
    .memData   (memDataOut)
  );

  always_comb begin
    stateNext = state;
    case (state)
      IDLE, REG_WB: begin
        if (accept) begin
          if (killIn)                    stateNext = HALTED;
          else if (isMemoryAccessDestIn) stateNext = MEM_REQ;
          else                           stateNext = REG_WB;
        end else begin
          stateNext = IDLE;
        end
      end
      MEM_REQ: if (storeDone) stateNext = IDLE;
      HALTED:  stateNext = HALTED;
      default: stateNext = IDLE;
    endcase
  end

  // An instruction leaves the stage either at the end of its REG_WB cycle or
  // on the edge its store ack is sampled. A kill retires on its own accept
  // edge; a REG_WB instruction retiring on that same edge also counts.
  assign retireOld  = (state == REG_WB) || ((state == MEM_REQ) && storeDone);
  assign retireKill = accept && killIn;

  // Capture stage: state, input fields and retirement bookkeeping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state             <= IDLE;
      rip_p1            <= '0;
      result_p1         <= '0;
      resultSpecial_p1  <= '0;
      destReg_p1        <= '0;
      destRegSpecial_p1 <= '0;
      specialValid_p1   <= 1'b0;
      retiredRip        <= '0;
      retiredCount      <= '0;
    end else begin
      state <= stateNext;
      if (accept) begin
        rip_p1            <= currentRipIn;
        result_p1         <= aluResultIn;
        resultSpecial_p1  <= aluResultSpecialIn;
        destReg_p1        <= destRegIn;
        destRegSpecial_p1 <= destRegSpecialIn;
        specialValid_p1   <= destRegSpecialValidIn;
      end
      retiredCount <= retiredCount
                    + {{(DATA_W-1){1'b0}}, retireOld}
                    + {{(DATA_W-1){1'b0}}, retireKill};
      if (retireKill)     retiredRip <= currentRipIn;
      else if (retireOld) retiredRip <= rip_p1;
    end
  end

  // When both writes target the same register the special result wins.
  assign specialShadows = specialValid_p1 && (destReg_p1 == destRegSpecial_p1);

  assign regWriteEnOut          = (state == REG_WB) && !specialShadows;
  assign regWriteAddrOut        = destReg_p1;
  assign regWriteDataOut        = result_p1;
  assign regWriteSpecialEnOut   = specialValid_p1 &&
                                  ((state == REG_WB) || ((state == MEM_REQ) && storeDone));
  assign regWriteSpecialAddrOut = destRegSpecial_p1;
  assign regWriteSpecialDataOut = resultSpecial_p1;

  assign memReqOut       = storeBusy;
  assign wbStallOut      = (state == MEM_REQ) || (state == HALTED);
  assign haltOut         = (state == HALTED);
  assign retiredRipOut   = retiredRip;
  assign retiredCountOut = retiredCount;

`ifdef WB_BYPASS_EN
  // Forward whatever lands in the destination register this REG_WB cycle.
  always_comb begin
    bypassValidOut = 1'b0;
    bypassRegOut   = '0;
    bypassDataOut  = '0;
    if (state == REG_WB) begin
      bypassValidOut = 1'b1;
      if (specialShadows) begin
        bypassRegOut  = destRegSpecial_p1;
        bypassDataOut = resultSpecial_p1;
      end else begin
        bypassRegOut  = destReg_p1;
        bypassDataOut = result_p1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_writeback.sv
// tb_writeback
//   Directed bench for the writeback stage: register writes, back-to-back
//   results, delayed and immediate store acks, dual/equal-code writes,
//   kill/halt and asynchronous reset during a store.
module tb_writeback;

  logic        clk;
  logic        reset;
  logic        isExecuteSuccessfulIn;
  logic        killIn;
  logic [63:0] currentRipIn;
  logic [63:0] aluResultIn;
  logic [63:0] aluResultSpecialIn;
  logic [3:0]  destRegIn;
  logic [3:0]  destRegSpecialIn;
  logic        destRegSpecialValidIn;
  logic        isMemoryAccessDestIn;
  logic [63:0] memoryAddressDestIn;
  logic        memAckIn;
  logic        regWriteEnOut;
  logic [3:0]  regWriteAddrOut;
  logic [63:0] regWriteDataOut;
  logic        regWriteSpecialEnOut;
  logic [3:0]  regWriteSpecialAddrOut;
  logic [63:0] regWriteSpecialDataOut;
  logic        memReqOut;
  logic [63:0] memAddrOut;
  logic [63:0] memDataOut;
  logic        wbStallOut;
  logic        haltOut;
  logic [63:0] retiredRipOut;
  logic [63:0] retiredCountOut;

  int checks = 0;
  int errors = 0;

  writeback dut (
    .clk                   (clk),
    .reset                 (reset),
    .isExecuteSuccessfulIn (isExecuteSuccessfulIn),
    .killIn                (killIn),
    .currentRipIn          (currentRipIn),
    .aluResultIn           (aluResultIn),
    .aluResultSpecialIn    (aluResultSpecialIn),
    .destRegIn             (destRegIn),
    .destRegSpecialIn      (destRegSpecialIn),
    .destRegSpecialValidIn (destRegSpecialValidIn),
    .isMemoryAccessDestIn  (isMemoryAccessDestIn),
    .memoryAddressDestIn   (memoryAddressDestIn),
    .memAckIn              (memAckIn),
    .regWriteEnOut         (regWriteEnOut),
    .regWriteAddrOut       (regWriteAddrOut),
    .regWriteDataOut       (regWriteDataOut),
    .regWriteSpecialEnOut  (regWriteSpecialEnOut),
    .regWriteSpecialAddrOut(regWriteSpecialAddrOut),
    .regWriteSpecialDataOut(regWriteSpecialDataOut),
    .memReqOut             (memReqOut),
    .memAddrOut            (memAddrOut),
    .memDataOut            (memDataOut),
    .wbStallOut            (wbStallOut),
    .haltOut               (haltOut),
    .retiredRipOut         (retiredRipOut),
    .retiredCountOut       (retiredCountOut)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic kill, input logic [63:0] rip, input logic [63:0] res,
                       input logic [63:0] resS, input logic [3:0] dst, input logic [3:0] dstS,
                       input logic sv, input logic isMem, input logic [63:0] addr);
    isExecuteSuccessfulIn = 1'b1;
    killIn                = kill;
    currentRipIn          = rip;
    aluResultIn           = res;
    aluResultSpecialIn    = resS;
    destRegIn             = dst;
    destRegSpecialIn      = dstS;
    destRegSpecialValidIn = sv;
    isMemoryAccessDestIn  = isMem;
    memoryAddressDestIn   = addr;
  endtask

  task automatic clearIn();
    isExecuteSuccessfulIn = 1'b0;
    killIn                = 1'b0;
    isMemoryAccessDestIn  = 1'b0;
    destRegSpecialValidIn = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    memAckIn = 1'b0;
    currentRipIn = '0; aluResultIn = '0; aluResultSpecialIn = '0;
    destRegIn = '0; destRegSpecialIn = '0; memoryAddressDestIn = '0;
    clearIn();
    tick(); tick();

    // Reset state
    chk("rst_wen",   regWriteEnOut, 0);
    chk("rst_swen",  regWriteSpecialEnOut, 0);
    chk("rst_req",   memReqOut, 0);
    chk("rst_stall", wbStallOut, 0);
    chk("rst_halt",  haltOut, 0);
    chk("rst_count", retiredCountOut, 0);
    chk("rst_rip",   retiredRipOut, 0);
    chk("rst_waddr", regWriteDataOut, 0);
    chk("rst_maddr", memAddrOut, 0);
    reset = 1'b0;
    tick();

    // ADD 0x5 -> reg 3
    offer(0, 64'h400000, 64'h5, 0, 4'd3, 4'd0, 0, 0, 0);
    tick(); clearIn(); #1;
    chk("add_wen",   regWriteEnOut, 1);
    chk("add_addr",  regWriteAddrOut, 3);
    chk("add_data",  regWriteDataOut, 64'h5);
    chk("add_swen",  regWriteSpecialEnOut, 0);
    chk("add_cnt0",  retiredCountOut, 0);
    tick();
    chk("add_wen_off", regWriteEnOut, 0);
    chk("add_cnt",   retiredCountOut, 1);
    chk("add_rip",   retiredRipOut, 64'h400000);

    // Three back-to-back register results
    offer(0, 64'h400010, 64'h11, 0, 4'd1, 4'd0, 0, 0, 0);
    tick();
    offer(0, 64'h400014, 64'h22, 0, 4'd2, 4'd0, 0, 0, 0); #1;
    chk("b2b1_wen",  regWriteEnOut, 1);
    chk("b2b1_data", regWriteDataOut, 64'h11);
    chk("b2b1_stall", wbStallOut, 0);
    tick();
    offer(0, 64'h400018, 64'h33, 0, 4'd4, 4'd0, 0, 0, 0); #1;
    chk("b2b2_wen",  regWriteEnOut, 1);
    chk("b2b2_addr", regWriteAddrOut, 2);
    chk("b2b2_data", regWriteDataOut, 64'h22);
    chk("b2b2_stall", wbStallOut, 0);
    tick(); clearIn(); #1;
    chk("b2b3_wen",  regWriteEnOut, 1);
    chk("b2b3_addr", regWriteAddrOut, 4);
    chk("b2b3_data", regWriteDataOut, 64'h33);
    tick();
    chk("b2b_cnt",   retiredCountOut, 4);
    chk("b2b_rip",   retiredRipOut, 64'h400018);

    // Store 0xDEAD to 0x1000, ack in the fourth request cycle
    offer(0, 64'h400100, 64'hDEAD, 0, 4'd5, 4'd0, 0, 1, 64'h1000);
    tick();
    offer(0, 64'h400200, 64'h77, 0, 4'd6, 4'd0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      if (i == 3) begin
        memAckIn = 1'b1;
        clearIn();
      end
      #1;
      chk("st_req",   memReqOut, 1);
      chk("st_stall", wbStallOut, 1);
      chk("st_addr",  memAddrOut, 64'h1000);
      chk("st_data",  memDataOut, 64'hDEAD);
      chk("st_wen",   regWriteEnOut, 0);
      chk("st_cnt",   retiredCountOut, 4);
      tick();
    end
    memAckIn = 1'b0; #1;
    chk("st_req_drop", memReqOut, 0);
    chk("st_stall_drop", wbStallOut, 0);
    chk("st_cnt_done", retiredCountOut, 5);
    chk("st_rip",    retiredRipOut, 64'h400100);
    tick();
    chk("st_nocap_wen", regWriteEnOut, 0);
    chk("st_nocap_cnt", retiredCountOut, 5);

    // Ack outside MEM_REQ is ignored
    memAckIn = 1'b1;
    tick();
    chk("ack_idle_req", memReqOut, 0);
    chk("ack_idle_cnt", retiredCountOut, 5);
    memAckIn = 1'b0;

    // Store with special write, ack in the first request cycle
    offer(0, 64'h400300, 64'hBEEF, 64'h9, 4'd0, 4'd2, 1, 1, 64'h2000);
    tick(); clearIn();
    memAckIn = 1'b1; #1;
    chk("st1_req",   memReqOut, 1);
    chk("st1_stall", wbStallOut, 1);
    chk("st1_swen",  regWriteSpecialEnOut, 1);
    chk("st1_saddr", regWriteSpecialAddrOut, 2);
    chk("st1_sdata", regWriteSpecialDataOut, 64'h9);
    chk("st1_wen",   regWriteEnOut, 0);
    tick();
    memAckIn = 1'b0; #1;
    chk("st1_req_drop", memReqOut, 0);
    chk("st1_swen_off", regWriteSpecialEnOut, 0);
    chk("st1_cnt",   retiredCountOut, 6);

    // MUL: dest 0 and special RDX both written
    offer(0, 64'h400400, 64'h10, 64'h1, 4'd0, 4'd2, 1, 0, 0);
    tick(); clearIn(); #1;
    chk("mul_wen",   regWriteEnOut, 1);
    chk("mul_addr",  regWriteAddrOut, 0);
    chk("mul_data",  regWriteDataOut, 64'h10);
    chk("mul_swen",  regWriteSpecialEnOut, 1);
    chk("mul_saddr", regWriteSpecialAddrOut, 2);
    chk("mul_sdata", regWriteSpecialDataOut, 64'h1);
    tick();
    chk("mul_cnt",   retiredCountOut, 7);

    // Equal destination codes: only the special write
    offer(0, 64'h400410, 64'h10, 64'h1, 4'd2, 4'd2, 1, 0, 0);
    tick(); clearIn(); #1;
    chk("eq_wen",    regWriteEnOut, 0);
    chk("eq_swen",   regWriteSpecialEnOut, 1);
    chk("eq_saddr",  regWriteSpecialAddrOut, 2);
    chk("eq_sdata",  regWriteSpecialDataOut, 64'h1);
    tick();
    chk("eq_cnt",    retiredCountOut, 8);

    // Kill at RIP 0x400080
    offer(1, 64'h400080, 64'h0, 0, 4'd7, 4'd0, 0, 0, 0);
    tick(); clearIn(); #1;
    chk("kill_halt",  haltOut, 1);
    chk("kill_stall", wbStallOut, 1);
    chk("kill_rip",   retiredRipOut, 64'h400080);
    chk("kill_cnt",   retiredCountOut, 9);
    chk("kill_wen",   regWriteEnOut, 0);
    offer(0, 64'h400500, 64'h55, 64'h66, 4'd8, 4'd9, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("halt_wen",  regWriteEnOut, 0);
      chk("halt_swen", regWriteSpecialEnOut, 0);
      chk("halt_hold", haltOut, 1);
      chk("halt_cnt",  retiredCountOut, 9);
    end
    clearIn();

    // Reset mid-store: request drops without a clock edge
    reset = 1'b1;
    tick();
    reset = 1'b0;
    offer(0, 64'h400600, 64'hCAFE, 0, 4'd1, 4'd0, 0, 1, 64'h3000);
    tick(); clearIn(); #1;
    chk("rs_req",    memReqOut, 1);
    chk("rs_cnt0",   retiredCountOut, 0);
    reset = 1'b1; #1;
    chk("rs_req_async", memReqOut, 0);
    chk("rs_stall",  wbStallOut, 0);
    chk("rs_halt",   haltOut, 0);
    chk("rs_cnt",    retiredCountOut, 0);
    tick();
    reset = 1'b0;
    offer(0, 64'h400700, 64'h42, 0, 4'd3, 4'd0, 0, 0, 0);
    tick(); clearIn(); #1;
    chk("rs_idle_wen",  regWriteEnOut, 1);
    chk("rs_idle_data", regWriteDataOut, 64'h42);
    tick();
    chk("rs_idle_cnt",  retiredCountOut, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
